// File: rtl/csr_file.sv
// Machine-mode CSR register file: decode/read mux, masked CSR writes,
// 64-bit cycle/instret counters, and trap-entry / mret state updates.
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA        = 32'h4000_0100,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_valid,
    input  logic [11:0] csr_addr,
    input  logic        csr_we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        illegal,
    input  logic        retire,
    input  logic        trap,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_o
);

    logic        mstatus_mie_reg;
    logic        mstatus_mpie_reg;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;

    // Index 0 is mcycle, index 1 is minstret.
    logic [1:0][63:0] cnt_reg;
    logic [1:0][63:0] cnt_next;

    logic        implemented;
    logic        read_only;
    logic        csr_write;
    logic [31:0] mstatus_val;

    // MPP is hardwired to machine mode (2'b11); only MIE/MPIE are stored.
    assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};

    // Address decode and read mux; unimplemented addresses read as zero.
    always_comb begin
        implemented = 1'b1;
        rdata       = 32'h0;
        case (csr_addr)
            12'h300: rdata = mstatus_val;
            12'h301: rdata = MISA;
            12'h304: rdata = mie_reg;
            12'h305: rdata = mtvec_reg;
            12'h340: rdata = mscratch_reg;
            12'h341: rdata = mepc_reg;
            12'h342: rdata = mcause_reg;
            12'h343: rdata = mtval_reg;
            12'h344: rdata = 32'h0;
            12'hB00, 12'hC00: rdata = cnt_reg[0][31:0];
            12'hB80, 12'hC80: rdata = cnt_reg[0][63:32];
            12'hB02, 12'hC02: rdata = cnt_reg[1][31:0];
            12'hB82, 12'hC82: rdata = cnt_reg[1][63:32];
            12'hF11, 12'hF12, 12'hF13: rdata = 32'h0;
            12'hF14: rdata = HART_ID;
            default: implemented = 1'b0;
        endcase
    end

    assign read_only = (csr_addr[11:10] == 2'b11);
    assign illegal   = csr_valid & (~implemented | (csr_we & read_only));
    // Trap and mret both outrank a CSR write; the whole write is dropped.
    assign csr_write = csr_valid & csr_we & ~illegal & ~trap & ~mret;

    // Per-counter next value: a write to either half replaces the increment.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            localparam logic [11:0] LO_ADDR = 12'hB00 + 12'(2 * gi);
            localparam logic [11:0] HI_ADDR = 12'hB80 + 12'(2 * gi);
            logic inc;
            if (gi == 0) begin : g_cycle
                assign inc = 1'b1;
            end else begin : g_instret
                assign inc = retire;
            end
            assign cnt_next[gi] = (csr_write && csr_addr == LO_ADDR) ? {cnt_reg[gi][63:32], wdata} :
                                  (csr_write && csr_addr == HI_ADDR) ? {wdata, cnt_reg[gi][31:0]} :
                                  cnt_reg[gi] + {63'b0, inc};
        end
    endgenerate

    // Counter state update.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Architectural CSR state: reset > trap > mret > CSR write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= 32'h0;
            mtvec_reg        <= RESET_MTVEC;
            mscratch_reg     <= 32'h0;
            mepc_reg         <= 32'h0;
            mcause_reg       <= 32'h0;
            mtval_reg        <= 32'h0;
        end else if (trap) begin
            mepc_reg         <= trap_pc & 32'hFFFF_FFFC;
            mcause_reg       <= trap_cause;
            mtval_reg        <= trap_val;
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
        end else if (mret) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
        end else if (csr_write) begin
            case (csr_addr)
                12'h300: begin
                    mstatus_mie_reg  <= wdata[3];
                    mstatus_mpie_reg <= wdata[7];
                end
                12'h304: mie_reg      <= wdata & 32'h0000_0888;
                12'h305: mtvec_reg    <= wdata & 32'hFFFF_FFFC;
                12'h340: mscratch_reg <= wdata;
                12'h341: mepc_reg     <= wdata & 32'hFFFF_FFFC;
                12'h342: mcause_reg   <= wdata;
                12'h343: mtval_reg    <= wdata;
                default: ;
            endcase
        end
    end

    assign mtvec_o = mtvec_reg;
    assign mepc_o  = mepc_reg;
    assign mie_o   = mstatus_mie_reg;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic, all cross-checked against a
// behavioural CSR model.
module tb_csr_file;

    localparam logic [31:0] HART = 32'd5;
    localparam logic [31:0] MISA_V = 32'h4000_0100;
    localparam logic [31:0] RMTVEC = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        reset, csr_valid, csr_we, retire, trap, mret;
    logic [11:0] csr_addr;
    logic [31:0] wdata, trap_cause, trap_pc, trap_val;
    logic [31:0] rdata, mtvec_o, mepc_o;
    logic        illegal, mie_o;

    csr_file #(.HART_ID(HART), .MISA(MISA_V), .RESET_MTVEC(RMTVEC)) dut (
        .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_addr(csr_addr),
        .csr_we(csr_we), .wdata(wdata), .rdata(rdata), .illegal(illegal),
        .retire(retire), .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_val(trap_val), .mret(mret), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
        .mie_o(mie_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, valid, we;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        trap, mret, retire;
        logic [31:0] tcause, tpc, tval;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [31:0] m_status, m_mie, m_mtvec, m_scratch, m_mepc, m_mcause, m_mtval;
    bit   [63:0] m_cyc, m_ins;

    function automatic vec_t mk(input logic v, input logic we, input logic [11:0] a,
                                input logic [31:0] wd, input logic chk,
                                input logic [31:0] erd, input logic eill);
        vec_t r;
        r.rst = 1'b0; r.valid = v; r.we = we; r.addr = a; r.wd = wd;
        r.trap = 1'b0; r.mret = 1'b0; r.retire = 1'b0;
        r.tcause = 32'h0; r.tpc = 32'h0; r.tval = 32'h0;
        r.chk = chk; r.exp_rd = erd; r.exp_ill = eill;
        return r;
    endfunction

    function automatic vec_t rd(input logic [11:0] a, input logic [31:0] e);
        return mk(1'b1, 1'b0, a, 32'h0, 1'b1, e, 1'b0);
    endfunction

    function automatic vec_t wr(input logic [11:0] a, input logic [31:0] d);
        return mk(1'b1, 1'b1, a, d, 1'b0, 32'h0, 1'b0);
    endfunction

    function automatic logic m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                         12'hC80, 12'hC02, 12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_status | 32'h0000_1800;
            12'h301: return MISA_V;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_scratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_update(input vec_t v);
        bit [63:0] nc, ni;
        logic ok;
        if (v.rst) begin
            m_status = 0; m_mie = 0; m_mtvec = RMTVEC; m_scratch = 0;
            m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
            return;
        end
        nc = m_cyc + 64'd1;
        ni = m_ins + (v.retire ? 64'd1 : 64'd0);
        ok = v.valid && v.we && m_impl(v.addr) && (v.addr[11:10] != 2'b11);
        if (v.trap) begin
            m_mepc = v.tpc & ~32'h3; m_mcause = v.tcause; m_mtval = v.tval;
            m_status = m_status[3] ? 32'h80 : 32'h0;
        end else if (v.mret) begin
            m_status = 32'h80 | (m_status[7] ? 32'h8 : 32'h0);
        end else if (ok) begin
            case (v.addr)
                12'h300: m_status = v.wd & 32'h88;
                12'h304: m_mie = v.wd & 32'h888;
                12'h305: m_mtvec = v.wd & ~32'h3;
                12'h340: m_scratch = v.wd;
                12'h341: m_mepc = v.wd & ~32'h3;
                12'h342: m_mcause = v.wd;
                12'h343: m_mtval = v.wd;
                12'hB00: nc = {m_cyc[63:32], v.wd};
                12'hB80: nc = {v.wd, m_cyc[31:0]};
                12'hB02: ni = {m_ins[63:32], v.wd};
                12'hB82: ni = {v.wd, m_ins[31:0]};
                default: ;
            endcase
        end
        m_cyc = nc;
        m_ins = ni;
    endfunction

    task automatic check(input string nm, input logic [11:0] a,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s addr=%h: got %h, expected %h", nm, a, act, exp);
        end
    endtask

    // One clock: drive, check combinational outputs, clock, check registered outputs.
    task automatic step(input vec_t v, input string nm);
        logic ill_m;
        reset = v.rst; csr_valid = v.valid; csr_we = v.we; csr_addr = v.addr;
        wdata = v.wd; trap = v.trap; mret = v.mret; retire = v.retire;
        trap_cause = v.tcause; trap_pc = v.tpc; trap_val = v.tval;
        #1;
        ill_m = v.valid & (~m_impl(v.addr) | (v.we & (v.addr[11:10] == 2'b11)));
        check({nm, ".rdata_model"}, v.addr, rdata, m_read(v.addr));
        check({nm, ".illegal_model"}, v.addr, {31'b0, illegal}, {31'b0, ill_m});
        if (v.chk) begin
            check({nm, ".rdata"}, v.addr, rdata, v.exp_rd);
            check({nm, ".illegal"}, v.addr, {31'b0, illegal}, {31'b0, v.exp_ill});
        end
        @(posedge clk);
        m_update(v);
        #1;
        check({nm, ".mtvec_o"}, v.addr, mtvec_o, m_mtvec);
        check({nm, ".mepc_o"}, v.addr, mepc_o, m_mepc);
        check({nm, ".mie_o"}, v.addr, {31'b0, mie_o}, {31'b0, m_status[3]});
        $display("step %-10s rst=%0b v=%0b we=%0b addr=%h wd=%h trap=%0b mret=%0b ret=%0b rdata=%h ill=%0b",
                 nm, v.rst, v.valid, v.we, v.addr, v.wd, v.trap, v.mret, v.retire, rdata, illegal);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [11:0] alist[23];

        m_status = 0; m_mie = 0; m_mtvec = RMTVEC; m_scratch = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;

        // Directed table: cycle counter at entry k (k>=1) is k-1 unless rewritten.
        v = mk(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 32'h0, 1'b0); v.rst = 1'b1;
        tbl.push_back(v);                                                   // 0
        tbl.push_back(rd(12'h300, 32'h0000_1800));                          // 1
        tbl.push_back(rd(12'h305, RMTVEC));                                 // 2
        tbl.push_back(rd(12'hF14, HART));                                   // 3
        tbl.push_back(mk(1, 1, 12'h305, 32'hFFFF_FFFF, 1, RMTVEC, 0));      // 4
        tbl.push_back(rd(12'h305, 32'hFFFF_FFFC));                          // 5
        tbl.push_back(mk(1, 1, 12'h300, 32'hFFFF_FFFF, 1, 32'h1800, 0));    // 6
        tbl.push_back(rd(12'h300, 32'h0000_1888));                          // 7
        tbl.push_back(mk(1, 1, 12'hC00, 32'h1234, 1, 32'd7, 1));            // 8
        tbl.push_back(mk(1, 1, 12'h7C0, 32'h1234, 1, 32'h0, 1));            // 9
        tbl.push_back(rd(12'hC00, 32'd9));                                  // 10
        tbl.push_back(rd(12'hF11, 32'h0));                                  // 11
        tbl.push_back(mk(1, 1, 12'h304, 32'hFFFF_FFFF, 1, 32'h0, 0));       // 12
        tbl.push_back(rd(12'h304, 32'h0000_0888));                          // 13
        tbl.push_back(mk(1, 1, 12'h341, 32'h1234_5677, 1, 32'h0, 0));       // 14
        tbl.push_back(rd(12'h341, 32'h1234_5674));                          // 15
        tbl.push_back(mk(1, 1, 12'h344, 32'hFFFF_FFFF, 1, 32'h0, 0));       // 16
        tbl.push_back(rd(12'h344, 32'h0));                                  // 17
        tbl.push_back(rd(12'h301, MISA_V));                                 // 18
        tbl.push_back(mk(1, 1, 12'hB00, 32'd5, 1, 32'd18, 0));              // 19
        tbl.push_back(rd(12'hB00, 32'd5));                                  // 20
        tbl.push_back(rd(12'hB00, 32'd6));                                  // 21
        tbl.push_back(rd(12'hC80, 32'h0));                                  // 22
        tbl.push_back(mk(1, 0, 12'h7C0, 32'h0, 1, 32'h0, 1));               // 23
        tbl.push_back(mk(0, 0, 12'h7C0, 32'h0, 1, 32'h0, 0));               // 24
        foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

        // mcycle carry from lo into hi
        step(wr(12'hB00, 32'hFFFF_FFFF), "cyc_lo");
        step(wr(12'hB80, 32'h0), "cyc_hi");
        step(rd(12'hB00, 32'hFFFF_FFFF), "cyc_pre");
        step(rd(12'hB00, 32'h0), "cyc_lo0");
        step(rd(12'hB80, 32'h1), "cyc_hi1");

        // minstret full 64-bit wrap on a retire
        step(wr(12'hB02, 32'hFFFF_FFFF), "ins_lo");
        step(wr(12'hB82, 32'hFFFF_FFFF), "ins_hi");
        v = rd(12'hC02, 32'hFFFF_FFFF); v.retire = 1'b1;
        step(v, "ins_wrap");
        step(rd(12'hC02, 32'h0), "ins_lo0");
        step(rd(12'hC82, 32'h0), "ins_hi0");

        // Trap entry and mret
        step(wr(12'h300, 32'h0000_0008), "set_mie");
        v = mk(0, 0, 12'h000, 32'h0, 0, 32'h0, 0);
        v.trap = 1'b1; v.tpc = 32'h103; v.tcause = 32'd2; v.tval = 32'hDEAD;
        step(v, "trap");
        step(rd(12'h341, 32'h100), "trap_mepc");
        step(rd(12'h342, 32'd2), "trap_cause");
        step(rd(12'h343, 32'hDEAD), "trap_val");
        step(rd(12'h300, 32'h0000_1880), "trap_stat");
        v = mk(0, 0, 12'h000, 32'h0, 0, 32'h0, 0); v.mret = 1'b1;
        step(v, "mret");
        step(rd(12'h300, 32'h0000_1888), "mret_stat");

        // Trap drops a same-cycle write to an unrelated CSR
        step(wr(12'h340, 32'hAAAA_5555), "scr_wr");
        v = wr(12'h340, 32'h1234_5678);
        v.trap = 1'b1; v.tpc = 32'h204; v.tcause = 32'hB; v.tval = 32'h0;
        step(v, "trap_wr");
        step(rd(12'h340, 32'hAAAA_5555), "scr_keep");
        step(rd(12'h341, 32'h204), "trap2_mepc");
        step(rd(12'h342, 32'hB), "trap2_cause");

        // Reset mid-sequence
        v = mk(0, 0, 12'h000, 32'h0, 0, 32'h0, 0); v.rst = 1'b1;
        step(v, "reset2");
        step(rd(12'h300, 32'h0000_1800), "rst_stat");
        step(rd(12'h305, RMTVEC), "rst_mtvec");
        step(rd(12'h340, 32'h0), "rst_scr");
        step(rd(12'h341, 32'h0), "rst_mepc");
        step(rd(12'h342, 32'h0), "rst_cause");
        step(rd(12'h304, 32'h0), "rst_mie");
        step(rd(12'hC02, 32'h0), "rst_ins");

        // Randomized traffic against the model
        alist = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                  12'hC82, 12'hF11, 12'hF13, 12'hF14, 12'h7C0, 12'h123, 12'hF15};
        for (int i = 0; i < 400; i++) begin
            v = mk(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0);
            v.valid  = ($urandom_range(0, 3) != 0);
            v.we     = $urandom_range(0, 1) == 1;
            v.addr   = alist[$urandom_range(0, 22)];
            v.wd     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            v.trap   = ($urandom_range(0, 15) == 0);
            v.mret   = ($urandom_range(0, 15) == 0);
            v.retire = $urandom_range(0, 1) == 1;
            v.rst    = ($urandom_range(0, 63) == 0);
            v.tcause = $urandom(); v.tpc = $urandom(); v.tval = $urandom();
            step(v, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
